// File: rtl/mvm_axis_packetizer.sv
// Packs ELEMW-bit operand elements into DATAW-wide flits and emits them as
// fixed-length AXI-Stream packets toward the MVM NoC injection port.
module mvm_axis_packetizer #(
  parameter int DATAW         = 512,
  parameter int ELEMW         = 32,
  parameter int BYTEW         = DATAW / 8,
  parameter int IDW           = 4,
  parameter int DESTW         = 4,
  parameter int USERW         = 8,
  parameter int FLITS_PER_PKT = 4,
  parameter int PKTW          = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [PKTW-1:0]  NUM_PKTS,
  input  logic [DESTW-1:0] DEST_I,
  input  logic [IDW-1:0]   ID_I,
  output logic             DONE,
  output logic             BUSY,
  input  logic             in_valid,
  input  logic [ELEMW-1:0] in_data,
  output logic             in_ready,
  output logic             axis_tx_tvalid,
  output logic [DATAW-1:0] axis_tx_tdata,
  output logic [BYTEW-1:0] axis_tx_tstrb,
  output logic [BYTEW-1:0] axis_tx_tkeep,
  output logic [IDW-1:0]   axis_tx_tid,
  output logic [DESTW-1:0] axis_tx_tdest,
  output logic [USERW-1:0] axis_tx_tuser,
  output logic             axis_tx_tlast,
  input  logic             axis_tx_tready
);

  localparam int EPF = DATAW / ELEMW;
  localparam int ECW = (EPF > 1) ? $clog2(EPF) : 1;
  localparam int FCW = (FLITS_PER_PKT > 1) ? $clog2(FLITS_PER_PKT) : 1;
  localparam int UW  = (USERW < PKTW) ? USERW : PKTW;

  typedef enum logic [1:0] {IDLE, PACK, SEND, FIN} state_t;

  state_t           state_reg, state_next;
  logic [ECW-1:0]   elem_cnt_reg, elem_cnt_next;
  logic [FCW-1:0]   flit_cnt_reg, flit_cnt_next;
  logic [PKTW-1:0]  pkt_cnt_reg, pkt_cnt_next;
  logic [PKTW-1:0]  num_pkts_reg;
  logic [DESTW-1:0] dest_reg;
  logic [IDW-1:0]   id_reg;
  logic [ELEMW-1:0] lane_reg [EPF];

  logic accept;
  logic handshake;
  logic last_elem;
  logic last_flit;
  logic last_pkt;

  assign accept    = (state_reg == PACK) && in_valid;
  assign handshake = (state_reg == SEND) && axis_tx_tready;
  assign last_elem = (elem_cnt_reg == ECW'(EPF - 1));
  assign last_flit = (flit_cnt_reg == FCW'(FLITS_PER_PKT - 1));
  assign last_pkt  = (pkt_cnt_reg == num_pkts_reg - PKTW'(1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      elem_cnt_reg <= '0;
      flit_cnt_reg <= '0;
      pkt_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      elem_cnt_reg <= elem_cnt_next;
      flit_cnt_reg <= flit_cnt_next;
      pkt_cnt_reg  <= pkt_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    elem_cnt_next = elem_cnt_reg;
    flit_cnt_next = flit_cnt_reg;
    pkt_cnt_next  = pkt_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (START) begin
          elem_cnt_next = '0;
          flit_cnt_next = '0;
          pkt_cnt_next  = '0;
          state_next    = (NUM_PKTS == '0) ? FIN : PACK;
        end
      end
      PACK: begin
        if (accept) begin
          if (last_elem) begin
            elem_cnt_next = '0;
            state_next    = SEND;
          end else begin
            elem_cnt_next = elem_cnt_reg + ECW'(1);
          end
        end
      end
      SEND: begin
        if (handshake) begin
          if (last_flit) begin
            flit_cnt_next = '0;
            pkt_cnt_next  = pkt_cnt_reg + PKTW'(1);
            state_next    = last_pkt ? FIN : PACK;
          end else begin
            flit_cnt_next = flit_cnt_reg + FCW'(1);
            state_next    = PACK;
          end
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Launch parameters are captured once; a START seen outside IDLE never reaches here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      num_pkts_reg <= '0;
      dest_reg     <= '0;
      id_reg       <= '0;
    end else if ((state_reg == IDLE) && START) begin
      num_pkts_reg <= NUM_PKTS;
      dest_reg     <= DEST_I;
      id_reg       <= ID_I;
    end
  end

  // Lanes only load in PACK, so the flit held during SEND is stable under backpressure.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < EPF; i++) lane_reg[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < EPF; i++) begin
        if (elem_cnt_reg == ECW'(i)) lane_reg[i] <= in_data;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < EPF; gi++) begin : g_lane
      assign axis_tx_tdata[gi*ELEMW +: ELEMW] = lane_reg[gi];
    end
    if (EPF * ELEMW < DATAW) begin : g_pad
      assign axis_tx_tdata[DATAW-1:EPF*ELEMW] = '0;
    end
  endgenerate

  always_comb begin
    axis_tx_tuser         = '0;
    axis_tx_tuser[UW-1:0] = pkt_cnt_reg[UW-1:0];
  end

  assign axis_tx_tvalid = (state_reg == SEND);
  assign axis_tx_tlast  = (state_reg == SEND) && last_flit;
  assign axis_tx_tstrb  = '1;
  assign axis_tx_tkeep  = '1;
  assign axis_tx_tid    = id_reg;
  assign axis_tx_tdest  = dest_reg;
  assign in_ready       = (state_reg == PACK);
  assign DONE           = (state_reg == FIN);
  assign BUSY           = (state_reg != IDLE);

endmodule

// File: tb/tb_mvm_axis_packetizer.sv
// Directed bench for mvm_axis_packetizer: table of launch records plus
// hand-written reset / zero-packet sequences.
module tb_mvm_axis_packetizer;

  localparam int DATAW = 512;
  localparam int ELEMW = 32;
  localparam int BYTEW = DATAW / 8;
  localparam int IDW   = 4;
  localparam int DESTW = 4;
  localparam int USERW = 8;
  localparam int FPP   = 4;
  localparam int PKTW  = 8;
  localparam int EPF   = DATAW / ELEMW;

  logic             CLK;
  logic             RST;
  logic             START;
  logic [PKTW-1:0]  NUM_PKTS;
  logic [DESTW-1:0] DEST_I;
  logic [IDW-1:0]   ID_I;
  logic             DONE;
  logic             BUSY;
  logic             in_valid;
  logic [ELEMW-1:0] in_data;
  logic             in_ready;
  logic             axis_tx_tvalid;
  logic [DATAW-1:0] axis_tx_tdata;
  logic [BYTEW-1:0] axis_tx_tstrb;
  logic [BYTEW-1:0] axis_tx_tkeep;
  logic [IDW-1:0]   axis_tx_tid;
  logic [DESTW-1:0] axis_tx_tdest;
  logic [USERW-1:0] axis_tx_tuser;
  logic             axis_tx_tlast;
  logic             axis_tx_tready;

  mvm_axis_packetizer #(
    .DATAW(DATAW), .ELEMW(ELEMW), .BYTEW(BYTEW), .IDW(IDW), .DESTW(DESTW),
    .USERW(USERW), .FLITS_PER_PKT(FPP), .PKTW(PKTW)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .NUM_PKTS(NUM_PKTS), .DEST_I(DEST_I),
    .ID_I(ID_I), .DONE(DONE), .BUSY(BUSY), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .axis_tx_tvalid(axis_tx_tvalid), .axis_tx_tdata(axis_tx_tdata),
    .axis_tx_tstrb(axis_tx_tstrb), .axis_tx_tkeep(axis_tx_tkeep), .axis_tx_tid(axis_tx_tid),
    .axis_tx_tdest(axis_tx_tdest), .axis_tx_tuser(axis_tx_tuser), .axis_tx_tlast(axis_tx_tlast),
    .axis_tx_tready(axis_tx_tready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DATAW-1:0] act, input logic [DATAW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One launch: inputs plus hand-computed totals the run must reach.
  typedef struct {
    int          num_pkts;
    int          dest;
    int          id;
    int          stall;
    bit          gap;
    bit          start_in_send;
    logic [31:0] base;
    int          exp_flits;
    int          exp_elems;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_done"},   DONE, 0);
    chk({tag, "_busy"},   BUSY, 0);
    chk({tag, "_ready"},  in_ready, 0);
    chk({tag, "_tvalid"}, axis_tx_tvalid, 0);
    chk({tag, "_tlast"},  axis_tx_tlast, 0);
    chk({tag, "_tdata"},  axis_tx_tdata, 0);
    chk({tag, "_tid"},    axis_tx_tid, 0);
    chk({tag, "_tdest"},  axis_tx_tdest, 0);
    chk({tag, "_tuser"},  axis_tx_tuser, 0);
  endtask

  task automatic run_case(input int idx, input vec_t v);
    int elem_idx = 0;
    int flits = 0;
    int iter = 0;
    int stall_left = v.stall;
    int last_hs = -10;
    bit done_seen = 0;
    bit injected = 0;
    logic [DATAW-1:0] exp_data;

    START = 1; NUM_PKTS = PKTW'(v.num_pkts); DEST_I = DESTW'(v.dest); ID_I = IDW'(v.id);
    in_valid = 0; axis_tx_tready = 0;
    step();
    while (!done_seen && iter < 3000) begin
      START = 0;
      for (int k = 0; k < EPF; k++) exp_data[k*ELEMW +: ELEMW] = v.base + 32'(flits * EPF + k);
      axis_tx_tready = 0;
      if (axis_tx_tvalid) begin
        chk("tdata", axis_tx_tdata, exp_data);
        chk("tlast", axis_tx_tlast, ((flits % FPP) == FPP - 1));
        chk("tuser", axis_tx_tuser, flits / FPP);
        chk("tid", axis_tx_tid, v.id);
        chk("tdest", axis_tx_tdest, v.dest);
        chk("tkeep", axis_tx_tkeep, {BYTEW{1'b1}});
        chk("tstrb", axis_tx_tstrb, {BYTEW{1'b1}});
        chk("in_ready_in_send", in_ready, 0);
        if (v.start_in_send && !injected) begin
          START = 1; NUM_PKTS = 8'd200; DEST_I = ~DESTW'(v.dest); ID_I = ~IDW'(v.id);
          injected = 1;
        end
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          axis_tx_tready = 1;
          flits++;
          last_hs = iter;
        end
      end
      in_valid = v.gap ? (iter % 2 == 0) : 1'b1;
      in_data  = v.base + 32'(elem_idx);
      if (in_valid && in_ready) elem_idx++;
      if (DONE) begin
        chk("done_timing", iter, last_hs + 1);
        chk("flit_count", flits, v.exp_flits);
        chk("busy_in_fin", BUSY, 1);
        done_seen = 1;
      end
      step();
      iter++;
    end
    in_valid = 0; axis_tx_tready = 0;
    chk("done_seen_before_timeout", done_seen, 1);
    chk("elems_consumed", elem_idx, v.exp_elems);
    chk("done_single_pulse", DONE, 0);
    chk("busy_after_done", BUSY, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_extra_done", DONE, 0);
      chk("no_extra_tvalid", axis_tx_tvalid, 0);
    end
    $display("case %0d: pkts=%0d dest=%0d id=%0d stall=%0d gap=%0d flits=%0d elems=%0d",
             idx, v.num_pkts, v.dest, v.id, v.stall, v.gap, flits, elem_idx);
  endtask

  initial begin
    vecs[0] = '{num_pkts: 1, dest: 3, id: 2, stall: 0, gap: 0, start_in_send: 0, base: 32'h0,    exp_flits: 4,  exp_elems: 64};
    vecs[1] = '{num_pkts: 2, dest: 5, id: 1, stall: 5, gap: 0, start_in_send: 0, base: 32'h100,  exp_flits: 8,  exp_elems: 128};
    vecs[2] = '{num_pkts: 1, dest: 3, id: 2, stall: 0, gap: 1, start_in_send: 0, base: 32'h0,    exp_flits: 4,  exp_elems: 64};
    vecs[3] = '{num_pkts: 2, dest: 9, id: 6, stall: 0, gap: 0, start_in_send: 1, base: 32'h2000, exp_flits: 8,  exp_elems: 128};
    vecs[4] = '{num_pkts: 3, dest: 1, id: 7, stall: 2, gap: 1, start_in_send: 0, base: 32'h5000, exp_flits: 12, exp_elems: 192};

    RST = 1; START = 0; NUM_PKTS = 0; DEST_I = 0; ID_I = 0;
    in_valid = 0; in_data = 0; axis_tx_tready = 0;
    repeat (3) step();
    chk_reset_outputs("reset");
    RST = 0;
    step();

    for (int i = 0; i < 5; i++) run_case(i, vecs[i]);

    // Zero-packet launch: straight to FIN, no flits.
    START = 1; NUM_PKTS = 0; DEST_I = 4'd6; ID_I = 4'd6;
    step();
    START = 0;
    chk("zero_done", DONE, 1);
    chk("zero_busy", BUSY, 1);
    chk("zero_tvalid", axis_tx_tvalid, 0);
    chk("zero_ready", in_ready, 0);
    step();
    chk("zero_done_drop", DONE, 0);
    chk("zero_busy_drop", BUSY, 0);
    chk("zero_tvalid_after", axis_tx_tvalid, 0);
    $display("zero-packet launch: done pulse observed");

    // Reset after 7 elements of a partial flit.
    START = 1; NUM_PKTS = 1; DEST_I = 4'd7; ID_I = 4'd5;
    step();
    START = 0;
    for (int i = 0; i < 7; i++) begin
      chk("midpack_ready", in_ready, 1);
      in_valid = 1; in_data = 32'hDEAD0000 + 32'(i);
      step();
    end
    in_valid = 0;
    RST = 1;
    step();
    chk_reset_outputs("midpack_reset");
    RST = 0;
    step();
    $display("mid-PACK reset: outputs returned to reset values");
    run_case(5, '{num_pkts: 1, dest: 4, id: 4, stall: 0, gap: 0, start_in_send: 0, base: 32'h7000, exp_flits: 4, exp_elems: 64});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
